// File: rtl/sm_run_ctrl.sv
// Run/debug controller for schoolRISCV: gates the CPU clock enable for run, step and
// breakpoints, and streams the register file out while the core is halted.
module sm_run_ctrl #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned CYC_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmdValid,
   output logic             cmdReady,
   input  logic [1:0]       cmdOp,
   input  logic [CNT_W-1:0] cmdArg,
   input  logic             bpEnable,
   input  logic [31:0]      bpAddr,
   input  logic [31:0]      pc,
   output logic             cpuEn,
   output logic [4:0]       regAddr,
   input  logic [31:0]      regData,
   output logic             dumpValid,
   input  logic             dumpReady,
   output logic [4:0]       dumpAddr,
   output logic [31:0]      dumpData,
   output logic             dumpLast,
   output logic             halted,
   output logic [1:0]       haltCause,
   output logic [CYC_W-1:0] cycleCount
);

   typedef enum logic [2:0] {StHalt, StRun, StStep, StDump, StDumpEnd} stateT;

   localparam logic [1:0] OpHalt = 2'b00;
   localparam logic [1:0] OpRun  = 2'b01;
   localparam logic [1:0] OpStep = 2'b10;
   localparam logic [1:0] OpDump = 2'b11;

   localparam logic [1:0] CauseReset = 2'b00;
   localparam logic [1:0] CauseHost  = 2'b01;
   localparam logic [1:0] CauseBp    = 2'b10;
   localparam logic [1:0] CauseStep  = 2'b11;

   stateT            stateQ, stateD;
   logic [1:0]       causeQ, causeD;
   logic [CNT_W-1:0] stepCntQ, stepCntD;
   logic             bpSkipQ, bpSkipD;
   logic [4:0]       idxQ, idxD;
   logic             dumpValidQ, dumpValidD;
   logic [4:0]       dumpAddrQ, dumpAddrD;
   logic [31:0]      dumpDataQ, dumpDataD;
   logic             dumpLastQ, dumpLastD;
   logic [CYC_W-1:0] cycleCountQ, cycleCountD;

   logic accept;
   logic haltReq;
   logic bpHit;

   assign cmdReady = (stateQ == StHalt) || (stateQ == StRun) || (stateQ == StStep);
   assign accept   = cmdValid && cmdReady;
   assign haltReq  = accept && (cmdOp == OpHalt);
   // bpSkip lets a run resumed at the breakpoint PC execute that instruction.
   assign bpHit    = bpEnable && (pc == bpAddr) && !bpSkipQ;

   always_comb begin
      stateD     = stateQ;
      causeD     = causeQ;
      stepCntD   = stepCntQ;
      bpSkipD    = bpSkipQ;
      idxD       = idxQ;
      dumpValidD = dumpValidQ;
      dumpAddrD  = dumpAddrQ;
      dumpDataD  = dumpDataQ;
      dumpLastD  = dumpLastQ;
      cpuEn      = 1'b0;

      unique case (stateQ)
         StHalt: begin
            if (accept) begin
               unique case (cmdOp)
                  OpRun: begin
                     stateD  = StRun;
                     bpSkipD = 1'b1;
                  end
                  OpStep: begin
                     stateD   = StStep;
                     stepCntD = (cmdArg == '0) ? CNT_W'(1) : cmdArg;
                  end
                  OpDump: begin
                     stateD = StDump;
                     idxD   = 5'd0;
                  end
                  OpHalt: ;
               endcase
            end
         end
         StRun: begin
            cpuEn = !bpHit;
            if (!bpHit) bpSkipD = 1'b0;
            if (bpHit) begin
               stateD = StHalt;
               causeD = CauseBp;
            end else if (haltReq) begin
               stateD = StHalt;
               causeD = CauseHost;
            end
         end
         StStep: begin
            cpuEn    = 1'b1;
            stepCntD = stepCntQ - CNT_W'(1);
            if (haltReq) begin
               stateD = StHalt;
               causeD = CauseHost;
            end else if (stepCntQ == CNT_W'(1)) begin
               stateD = StHalt;
               causeD = CauseStep;
            end
         end
         StDump: begin
            if (!dumpValidQ || dumpReady) begin
               dumpValidD = 1'b1;
               dumpDataD  = regData;
               dumpAddrD  = idxQ;
               dumpLastD  = (idxQ == 5'd31);
               idxD       = idxQ + 5'd1;
               if (idxQ == 5'd31) stateD = StDumpEnd;
            end
         end
         StDumpEnd: begin
            if (dumpValidQ && dumpReady) begin
               dumpValidD = 1'b0;
               dumpLastD  = 1'b0;
               stateD     = StHalt;
            end
         end
         default: stateD = StHalt;
      endcase

      cycleCountD = cycleCountQ;
      if (cpuEn && (cycleCountQ != {CYC_W{1'b1}})) cycleCountD = cycleCountQ + CYC_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ      <= StHalt;
         causeQ      <= CauseReset;
         stepCntQ    <= '0;
         bpSkipQ     <= 1'b0;
         idxQ        <= 5'd0;
         dumpValidQ  <= 1'b0;
         dumpAddrQ   <= 5'd0;
         dumpDataQ   <= 32'd0;
         dumpLastQ   <= 1'b0;
         cycleCountQ <= '0;
      end else begin
         stateQ      <= stateD;
         causeQ      <= causeD;
         stepCntQ    <= stepCntD;
         bpSkipQ     <= bpSkipD;
         idxQ        <= idxD;
         dumpValidQ  <= dumpValidD;
         dumpAddrQ   <= dumpAddrD;
         dumpDataQ   <= dumpDataD;
         dumpLastQ   <= dumpLastD;
         cycleCountQ <= cycleCountD;
      end
   end

   // idx wraps back to 0 after register 31, so regAddr idles at 0 outside a dump.
   assign regAddr    = idxQ;
   assign dumpValid  = dumpValidQ;
   assign dumpAddr   = dumpAddrQ;
   assign dumpData   = dumpDataQ;
   assign dumpLast   = dumpLastQ;
   assign halted     = (stateQ == StHalt);
   assign haltCause  = causeQ;
   assign cycleCount = cycleCountQ;

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Directed bench for sm_run_ctrl: step, breakpoint, host halt, register dump and reset abort.
module tb_sm_run_ctrl;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned CYC_W = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmdValid = 1'b0;
   logic             cmdReady;
   logic [1:0]       cmdOp = 2'b00;
   logic [CNT_W-1:0] cmdArg = '0;
   logic             bpEnable = 1'b0;
   logic [31:0]      bpAddr = 32'd0;
   logic [31:0]      pc;
   logic             cpuEn;
   logic [4:0]       regAddr;
   logic [31:0]      regData;
   logic             dumpValid;
   logic             dumpReady = 1'b0;
   logic [4:0]       dumpAddr;
   logic [31:0]      dumpData;
   logic             dumpLast;
   logic             halted;
   logic [1:0]       haltCause;
   logic [CYC_W-1:0] cycleCount;

   logic             pcLoad = 1'b1;
   logic [31:0]      pcLoadVal = 32'd0;
   int               nCompared = 0;
   int               nMismatched = 0;
   int               enCnt = 0;
   int               base = 0;

   sm_run_ctrl #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmdValid   (cmdValid),
      .cmdReady   (cmdReady),
      .cmdOp      (cmdOp),
      .cmdArg     (cmdArg),
      .bpEnable   (bpEnable),
      .bpAddr     (bpAddr),
      .pc         (pc),
      .cpuEn      (cpuEn),
      .regAddr    (regAddr),
      .regData    (regData),
      .dumpValid  (dumpValid),
      .dumpReady  (dumpReady),
      .dumpAddr   (dumpAddr),
      .dumpData   (dumpData),
      .dumpLast   (dumpLast),
      .halted     (halted),
      .haltCause  (haltCause),
      .cycleCount (cycleCount)
   );

   always #5 clk = ~clk;

   // Minimal core: PC advances by 4 on every enabled cycle.
   always @(posedge clk) begin
      if (pcLoad) pc <= pcLoadVal;
      else if (cpuEn) pc <= pc + 32'd4;
   end

   assign regData = 32'(regAddr) * 32'h11;

   always @(negedge clk) if (cpuEn === 1'b1) enCnt++;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Caller sits just after a rising edge; the command is accepted on the next edge.
   task automatic sendCmd(input logic [1:0] op, input logic [CNT_W-1:0] arg);
      cmdValid = 1'b1;
      cmdOp    = op;
      cmdArg   = arg;
      @(posedge clk);
      #1;
      cmdValid = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic setPc(input logic [31:0] v);
      pcLoad    = 1'b1;
      pcLoadVal = v;
      @(posedge clk);
      #1;
      pcLoad = 1'b0;
   endtask

   task automatic checkResetVals(input string tag);
      checkVal({tag, "_cpuEn"}, 64'(cpuEn), 64'(0));
      checkVal({tag, "_halted"}, 64'(halted), 64'(1));
      checkVal({tag, "_cause"}, 64'(haltCause), 64'(0));
      checkVal({tag, "_dValid"}, 64'(dumpValid), 64'(0));
      checkVal({tag, "_dLast"}, 64'(dumpLast), 64'(0));
      checkVal({tag, "_dAddr"}, 64'(dumpAddr), 64'(0));
      checkVal({tag, "_dData"}, 64'(dumpData), 64'(0));
      checkVal({tag, "_regAddr"}, 64'(regAddr), 64'(0));
      checkVal({tag, "_cycles"}, 64'(cycleCount), 64'(0));
      checkVal({tag, "_cmdReady"}, 64'(cmdReady), 64'(1));
   endtask

   task automatic doDump(input bit toggle, input int abortAt, input logic [1:0] expCause);
      int          idx = 0;
      int          cyc = 0;
      int          firstCyc = -1;
      logic [31:0] held = 32'd0;
      bit          stalled = 1'b0;
      dumpReady = 1'b1;
      sendCmd(2'b11, '0);
      checkVal("dump_cmdReady", 64'(cmdReady), 64'(0));
      checkVal("dump_halted", 64'(halted), 64'(0));
      while (idx < 32 && idx < abortAt && cyc < 200) begin
         @(negedge clk);
         if (stalled) checkVal("stall_data", 64'(dumpData), 64'(held));
         stalled = dumpValid && !dumpReady;
         held    = dumpData;
         if (dumpValid && firstCyc < 0) firstCyc = cyc;
         if (dumpValid && dumpReady) begin
            checkVal("beat_addr", 64'(dumpAddr), 64'(idx));
            checkVal("beat_data", 64'(dumpData), 64'(idx * 32'h11));
            checkVal("beat_last", 64'(dumpLast), 64'(idx == 31));
            checkVal("beat_cmdReady", 64'(cmdReady), 64'(0));
            idx++;
         end
         cyc++;
         @(posedge clk);
         #1;
         if (toggle) dumpReady = !dumpReady;
      end
      checkVal("dump_first_valid", 64'(firstCyc), 64'(1));
      if (abortAt >= 32) begin
         checkVal("dump_beats", 64'(idx), 64'(32));
         if (!toggle) checkVal("dump_no_gaps", 64'(cyc), 64'(33));
         checkVal("dump_end_halted", 64'(halted), 64'(1));
         checkVal("dump_end_valid", 64'(dumpValid), 64'(0));
         checkVal("dump_end_last", 64'(dumpLast), 64'(0));
         checkVal("dump_end_cause", 64'(haltCause), 64'(expCause));
         checkVal("dump_end_cmdReady", 64'(cmdReady), 64'(1));
      end else begin
         checkVal("dump_abort_beats", 64'(idx), 64'(abortAt));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      checkResetVals("reset");
      @(negedge clk);
      rst    = 1'b0;
      pcLoad = 1'b0;
      @(posedge clk);
      #1;

      // Step 3
      base = enCnt;
      sendCmd(2'b10, 16'd3);
      waitCycles(6);
      checkVal("step3_en", 64'(enCnt - base), 64'(3));
      checkVal("step3_halted", 64'(halted), 64'(1));
      checkVal("step3_cause", 64'(haltCause), 64'(3));
      checkVal("step3_cycles", 64'(cycleCount), 64'(3));
      checkVal("step3_pc", 64'(pc), 64'(32'h0C));

      // Breakpoint at 0x0C
      setPc(32'h0);
      bpEnable = 1'b1;
      bpAddr   = 32'h0C;
      base     = enCnt;
      sendCmd(2'b01, '0);
      waitCycles(8);
      checkVal("bp_en", 64'(enCnt - base), 64'(3));
      checkVal("bp_halted", 64'(halted), 64'(1));
      checkVal("bp_cause", 64'(haltCause), 64'(2));
      checkVal("bp_pc", 64'(pc), 64'(32'h0C));
      checkVal("bp_cpuEn", 64'(cpuEn), 64'(0));
      checkVal("bp_cycles", 64'(cycleCount), 64'(6));

      // Resume at the breakpoint PC, then host halt
      sendCmd(2'b01, '0);
      @(negedge clk);
      checkVal("resume_cpuEn", 64'(cpuEn), 64'(1));
      checkVal("resume_pc", 64'(pc), 64'(32'h0C));
      @(posedge clk);
      #1;
      sendCmd(2'b00, '0);
      waitCycles(2);
      checkVal("resume_pc_end", 64'(pc), 64'(32'h14));
      checkVal("resume_cause", 64'(haltCause), 64'(1));
      checkVal("resume_cycles", 64'(cycleCount), 64'(8));

      // Run, halt accepted 5 cycles later
      bpEnable = 1'b0;
      setPc(32'h100);
      base = enCnt;
      sendCmd(2'b01, '0);
      waitCycles(5);
      sendCmd(2'b00, '0);
      waitCycles(3);
      checkVal("halt_en", 64'(enCnt - base), 64'(6));
      checkVal("halt_cause", 64'(haltCause), 64'(1));
      checkVal("halt_pc", 64'(pc), 64'(32'h118));
      checkVal("halt_cycles", 64'(cycleCount), 64'(14));

      // Step 0 behaves as step 1
      base = enCnt;
      sendCmd(2'b10, 16'd0);
      waitCycles(4);
      checkVal("step0_en", 64'(enCnt - base), 64'(1));
      checkVal("step0_cause", 64'(haltCause), 64'(3));
      checkVal("step0_cycles", 64'(cycleCount), 64'(15));

      // Host halt wins mid-step
      base = enCnt;
      sendCmd(2'b10, 16'd10);
      waitCycles(2);
      sendCmd(2'b00, '0);
      waitCycles(3);
      checkVal("stephalt_en", 64'(enCnt - base), 64'(3));
      checkVal("stephalt_cause", 64'(haltCause), 64'(1));
      checkVal("stephalt_cycles", 64'(cycleCount), 64'(18));

      // Dumps
      doDump(1'b0, 32, 2'b01);
      doDump(1'b1, 32, 2'b01);

      // Reset during dump at beat 10, then a fresh dump
      doDump(1'b0, 10, 2'b01);
      rst = 1'b1;
      #1;
      checkResetVals("rst_dump");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      doDump(1'b0, 32, 2'b00);

      // Reset during run
      setPc(32'h0);
      sendCmd(2'b01, '0);
      waitCycles(3);
      checkVal("run_before_rst", 64'(cpuEn), 64'(1));
      rst = 1'b1;
      #1;
      checkResetVals("rst_run");
      @(negedge clk);
      rst = 1'b0;
      waitCycles(2);
      checkVal("after_rst_cycles", 64'(cycleCount), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule
